// File: rtl/mm_pkg.sv
// Shared types and default dimensions for the matrix-multiply feeder and array top.
package mm_pkg;

    typedef enum logic {
        LOAD   = 1'b0,
        STREAM = 1'b1
    } mm_state_e;

    localparam int unsigned MM_N          = 4;
    localparam int unsigned MM_K          = 4;
    localparam int unsigned MM_DATA_WIDTH = 8;
    localparam int unsigned MM_SKEW       = 2;

    // Cycles needed to push K beats through an N-deep skewed edge.
    function automatic int unsigned mm_stream_len(input int unsigned n,
                                                  input int unsigned k,
                                                  input int unsigned skew);
        return k + skew * (n - 1);
    endfunction

endpackage

// File: rtl/mm_feed_buf.sv
// K-deep operand buffer: one write port for a whole (A column, B row) beat,
// N independent read ports for A rows and N for B columns.
module mm_feed_buf
    import mm_pkg::*;
#(
    parameter int unsigned N          = MM_N,
    parameter int unsigned K          = MM_K,
    parameter int unsigned DATA_WIDTH = MM_DATA_WIDTH,
    parameter int unsigned AW         = (MM_K > 1) ? $clog2(MM_K) : 1
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic [AW-1:0]           waddr_i,
    input  logic [N*DATA_WIDTH-1:0] wdata_a_i,
    input  logic [N*DATA_WIDTH-1:0] wdata_b_i,
    input  logic [N*AW-1:0]         raddr_a_i,
    input  logic [N*AW-1:0]         raddr_b_i,
    output logic [N*DATA_WIDTH-1:0] rdata_a_o,
    output logic [N*DATA_WIDTH-1:0] rdata_b_o
);

    logic [N*DATA_WIDTH-1:0] mem_a_q [K];
    logic [N*DATA_WIDTH-1:0] mem_b_q [K];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_a_q[waddr_i] <= wdata_a_i;
            mem_b_q[waddr_i] <= wdata_b_i;
        end
    end

    // Port i only ever needs element i of its addressed slot.
    always_comb begin
        rdata_a_o = '0;
        rdata_b_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            rdata_a_o[i*DATA_WIDTH +: DATA_WIDTH] =
                mem_a_q[raddr_a_i[i*AW +: AW]][i*DATA_WIDTH +: DATA_WIDTH];
            rdata_b_o[i*DATA_WIDTH +: DATA_WIDTH] =
                mem_b_q[raddr_b_i[i*AW +: AW]][i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/mm_feeder.sv
// Loads K beats of A columns / B rows, then streams them skewed by SKEW per
// row/column into the edges of an N x N systolic array.
module mm_feeder
    import mm_pkg::*;
#(
    parameter int unsigned N          = MM_N,
    parameter int unsigned K          = MM_K,
    parameter int unsigned DATA_WIDTH = MM_DATA_WIDTH,
    parameter int unsigned SKEW       = MM_SKEW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] in_a,
    input  logic [N*DATA_WIDTH-1:0] in_b,
    output logic [N*DATA_WIDTH-1:0] a_out,
    output logic [N*DATA_WIDTH-1:0] b_out,
    output logic [N-1:0]            en_out,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned L  = mm_stream_len(N, K, SKEW);
    localparam int unsigned CW = $clog2(L + 1);
    localparam int unsigned WW = $clog2(K + 1);
    localparam int unsigned AW = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned W  = N * DATA_WIDTH;

    mm_state_e       state_q, state_d;
    logic [WW-1:0]   wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]   t_q, t_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [N-1:0]    en_q, en_d;
    logic            last_q, last_d;
    logic            done_q, done_d;

    logic            we;
    logic [AW-1:0]   waddr;
    logic [N-1:0]    win;
    logic [W-1:0]    win_mask;
    logic [N*AW-1:0] rd_addr;
    logic [W-1:0]    rd_a, rd_b;

    assign waddr = AW'(wr_cnt_q);

    mm_feed_buf #(
        .N          (N),
        .K          (K),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW)
    ) u_buf (
        .clk        (clk),
        .we_i       (we),
        .waddr_i    (waddr),
        .wdata_a_i  (in_a),
        .wdata_b_i  (in_b),
        .raddr_a_i  (rd_addr),
        .raddr_b_i  (rd_addr),
        .rdata_a_o  (rd_a),
        .rdata_b_o  (rd_b)
    );

    // Row i and column j share the window rule, so one address per lane serves both.
    always_comb begin
        win      = '0;
        win_mask = '0;
        rd_addr  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (t_q >= CW'(SKEW * i) && t_q < CW'(SKEW * i + K)) begin
                win[i]                               = 1'b1;
                win_mask[i*DATA_WIDTH +: DATA_WIDTH] = '1;
                rd_addr[i*AW +: AW]                  = AW'(t_q - CW'(SKEW * i));
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        t_d      = t_q;
        a_d      = '0;
        b_d      = '0;
        en_d     = '0;
        last_d   = 1'b0;
        done_d   = 1'b0;
        in_ready = 1'b0;
        we       = 1'b0;
        if (flush) begin
            state_d  = LOAD;
            wr_cnt_d = '0;
            t_d      = '0;
        end else begin
            done_d = last_q;
            unique case (state_q)
                LOAD: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        we = 1'b1;
                        if (wr_cnt_q == WW'(K - 1)) begin
                            wr_cnt_d = '0;
                            t_d      = '0;
                            state_d  = STREAM;
                        end else begin
                            wr_cnt_d = wr_cnt_q + 1'b1;
                        end
                    end
                end
                STREAM: begin
                    en_d = win;
                    a_d  = rd_a & win_mask;
                    b_d  = rd_b & win_mask;
                    if (t_q == CW'(L - 1)) begin
                        state_d = LOAD;
                        t_d     = '0;
                        last_d  = 1'b1;
                    end else begin
                        t_d = t_q + 1'b1;
                    end
                end
                default: state_d = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOAD;
            wr_cnt_q <= '0;
            t_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            en_q     <= '0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            t_q      <= t_d;
            a_q      <= a_d;
            b_q      <= b_d;
            en_q     <= en_d;
            last_q   <= last_d;
            done_q   <= done_d;
        end
    end

    assign a_out  = a_q;
    assign b_out  = b_q;
    assign en_out = en_q;
    assign busy   = (state_q == STREAM);
    assign done   = done_q;

endmodule
